// File: rtl/alu_exec_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_seq
// Description : EX-stage ALU that decodes ALUOp/funct and executes the op.
//               Single-cycle ops finish in one clock. MUL uses an iterative
//               shift-add unit that takes WIDTH clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_seq #(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             flush_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             illegal_o
);

    localparam int             CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [0:0]     c_st_idle  = 1'b0;
    localparam logic [0:0]     c_st_mul   = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_illegal;

    logic [WIDTH-1:0] w_result;
    logic             w_illegal;
    logic             w_is_mul;
    logic             w_accept;
    logic             w_mul_last;
    logic [WIDTH-1:0] w_acc_nxt;

    assign ready_o   = (r_state == c_st_idle);
    assign valid_o   = r_valid;
    assign data_o    = r_data;
    assign zero_o    = r_zero;
    assign illegal_o = r_illegal;

    assign w_accept   = valid_i & ready_o & ~flush_i;
    assign w_mul_last = (r_cnt == c_cnt_last);
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Decode and single-cycle execute; unknown R-type functs fall back to ADD.
    always_comb begin
        w_result  = data1_i + data2_i;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        case (ALUOp_i)
            2'b00: w_result = data1_i + data2_i;
            2'b01: w_result = data1_i - data2_i;
            2'b10: w_result = data1_i | data2_i;
            default: begin
                case (funct_i)
                    6'b100000: w_result = data1_i + data2_i;
                    6'b100010: w_result = data1_i - data2_i;
                    6'b100100: w_result = data1_i & data2_i;
                    6'b100101: w_result = data1_i | data2_i;
                    6'b101010: w_result = {{(WIDTH-1){1'b0}},
                                           ($signed(data1_i) < $signed(data2_i))};
                    6'b011000: begin
                        if (ENABLE_MUL) begin
                            w_is_mul = 1'b1;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = c_st_mul;
                end
            end
            default: begin
                if (flush_i || w_mul_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == c_st_idle) begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        r_mcand  <= data1_i;
                        r_mplier <= data2_i;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else begin
                        r_data    <= w_result;
                        r_zero    <= (w_result == '0);
                        r_illegal <= w_illegal;
                        r_valid   <= 1'b1;
                    end
                end
            end else if (!flush_i) begin
                // A flush simply abandons the partial product; the next MUL reloads it.
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_mul_last) begin
                    r_data    <= w_acc_nxt;
                    r_zero    <= (w_acc_nxt == '0);
                    r_illegal <= 1'b0;
                    r_valid   <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
